// File: rtl/rv_pkg.sv
// Shared writeback-path constants: register-file geometry and requester encoding.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant logic; pointer remembers the last granted requester.
module rr_arb2
  import rv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant
);

  req_e rr, rr_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr <= REQ_B;
    else      rr <= rr_next;
  end

  always_comb begin
    rr_next = rr;
    if (a_grant)      rr_next = REQ_A;
    else if (b_grant) rr_next = REQ_B;
  end

  // Grants are suppressed while reset is asserted so nothing is accepted during reset.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (rst && !hold) begin
      if (a_valid && b_valid) begin
        if (rr == REQ_B) a_grant = 1'b1;
        else             b_grant = 1'b1;
      end else begin
        a_grant = a_valid;
        b_grant = b_valid;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: merges execute (A) and load (B) writebacks into one write port with bypass.
module wb_arbiter #(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int AW   = rv_pkg::AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_addr,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [AW-1:0]   b_addr,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  output logic            WE,
  output logic [AW-1:0]   AddD,
  output logic [XLEN-1:0] DataD,
  input  logic [AW-1:0]   qa_addr,
  output logic            qa_hit,
  output logic [XLEN-1:0] qa_data,
  input  logic [AW-1:0]   qb_addr,
  output logic            qb_hit,
  output logic [XLEN-1:0] qb_data
);

  logic            wr;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .hold    (hold),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_grant (a_ready),
    .b_grant (b_ready)
  );

  always_comb begin
    sel_addr = b_ready ? b_addr : a_addr;
    sel_data = b_ready ? b_data : a_data;
    // x0 writes are accepted but never reach the register file
    wr       = (a_ready || b_ready) && (sel_addr != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WE    <= 1'b0;
      AddD  <= '0;
      DataD <= '0;
    end else begin
      WE <= wr;
      if (wr) begin
        AddD  <= sel_addr;
        DataD <= sel_data;
      end
    end
  end

  always_comb begin
    qa_hit  = WE && (AddD == qa_addr) && (qa_addr != '0);
    qb_hit  = WE && (AddD == qb_addr) && (qb_addr != '0);
    qa_data = qa_hit ? DataD : '0;
    qb_data = qb_hit ? DataD : '0;
  end

endmodule
